// File: rtl/unsigned_multiplier.sv
// Free-running shift-and-add unsigned multiplier: captures M/Q, iterates N
// add/shift steps, and holds the finished 2N-bit product on R until the next completion.
module unsigned_multiplier #(
   parameter int N = 3
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [N-1:0]   M,
   input  logic [N-1:0]   Q,
   output logic [2*N-1:0] R
);

   localparam int CW = $clog2(N + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]   state;
   logic [N-1:0] m_reg;
   logic [N-1:0] acc;
   logic         c;
   logic [N-1:0] q_reg;
   logic [CW-1:0] cnt;

   logic [N:0]   sum;
   logic [2*N:0] shifted;

   // One iteration: conditional add into the upper half (carry kept in the
   // extra bit), then shift the whole {c,acc,q_reg} chain right by one.
   always_comb begin
      sum = {c, acc};
      if (q_reg[0]) sum = {c, acc} + {1'b0, m_reg};
      shifted = {sum, q_reg} >> 1;
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         R     <= '0;
         state <= IDLE;
         m_reg <= '0;
         acc   <= '0;
         c     <= 1'b0;
         q_reg <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               m_reg <= M;
               q_reg <= Q;
               acc   <= '0;
               c     <= 1'b0;
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               acc   <= shifted[2*N-1:N];
               q_reg <= shifted[N-1:0];
               c     <= shifted[2*N];
               cnt   <= cnt + 1'b1;
               // Last iteration publishes the post-shift value directly.
               if (cnt == CW'(N - 1)) begin
                  R     <= shifted[2*N-1:0];
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_unsigned_multiplier.sv
// Directed bench for unsigned_multiplier: N=3, N=8 and N=1 instances share
// clock and reset; expected products are hand-computed constants or m*q.
module tb_unsigned_multiplier;

   logic       clk;
   logic       rstn;
   logic [2:0] m3, q3;
   logic [5:0] r3;
   logic [7:0] m8, q8;
   logic [15:0] r8;
   logic [0:0] m1, q1;
   logic [1:0] r1;

   int n_cmp = 0;
   int n_err = 0;

   unsigned_multiplier #(.N(3)) u3 (.clk(clk), .rstn(rstn), .M(m3), .Q(q3), .R(r3));
   unsigned_multiplier #(.N(8)) u8 (.clk(clk), .rstn(rstn), .M(m8), .Q(q8), .R(r8));
   unsigned_multiplier #(.N(1)) u1 (.clk(clk), .rstn(rstn), .M(m1), .Q(q1), .R(r1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One reset edge, then release; the next edge is the first capture.
   task automatic pulse_reset();
      rstn = 1'b1;
      tick(1);
      rstn = 1'b0;
   endtask

   task automatic test_reset();
      m3 = 3'd6; q3 = 3'd7;
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         n_cmp++;
         if (r3 !== 6'd0) begin
            n_err++; $display("FAIL reset_hold cyc%0d: got %0d want 0", i, r3);
         end
      end
      rstn = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         n_cmp++;
         if (r3 !== 6'd0) begin
            n_err++; $display("FAIL reset_release edge%0d: got %0d want 0", i, r3);
         end
      end
      tick(1);
      n_cmp++;
      if (r3 !== 6'd42) begin
         n_err++; $display("FAIL first_product: got %0d want 42", r3);
      end
      for (int i = 0; i < 8; i++) begin
         tick(1);
         n_cmp++;
         if (r3 !== 6'd42) begin
            n_err++; $display("FAIL stable_42 cyc%0d: got %0d want 42", i, r3);
         end
      end
   endtask

   task automatic test_operand_switch();
      m3 = 3'd6; q3 = 3'd7;
      pulse_reset();
      tick(4);
      n_cmp++;
      if (r3 !== 6'd42) begin
         n_err++; $display("FAIL switch_pre: got %0d want 42", r3);
      end
      m3 = 3'd3; q3 = 3'd4;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         n_cmp++;
         if (r3 !== 6'd42 && r3 !== 6'd12) begin
            n_err++; $display("FAIL switch_glitch cyc%0d: got %0d want 42 or 12", i, r3);
         end
      end
      n_cmp++;
      if (r3 !== 6'd12) begin
         n_err++; $display("FAIL switch_final: got %0d want 12", r3);
      end
   endtask

   task automatic test_max();
      m3 = 3'd7; q3 = 3'd7; m8 = 8'd255; q8 = 8'd255;
      pulse_reset();
      tick(4);
      n_cmp++;
      if (r3 !== 6'd49) begin
         n_err++; $display("FAIL max_n3: got %0d want 49", r3);
      end
      tick(5);
      n_cmp++;
      if (r8 !== 16'd65025) begin
         n_err++; $display("FAIL max_n8: got %0d want 65025", r8);
      end
   endtask

   task automatic test_wide();
      logic [7:0]  wm [3];
      logic [7:0]  wq [3];
      logic [15:0] we [3];
      wm = '{8'd200, 8'd255, 8'd128};
      wq = '{8'd100, 8'd1,   8'd2};
      we = '{16'd20000, 16'd255, 16'd256};
      for (int i = 0; i < 3; i++) begin
         m8 = wm[i]; q8 = wq[i];
         pulse_reset();
         tick(9);
         n_cmp++;
         if (r8 !== we[i]) begin
            n_err++; $display("FAIL wide_%0d: got %0d want %0d", i, r8, we[i]);
         end
      end
   endtask

   task automatic test_zero_identity();
      logic [2:0] zm [3];
      logic [2:0] zq [3];
      logic [5:0] ze [3];
      zm = '{3'd0, 3'd5, 3'd1};
      zq = '{3'd5, 3'd1, 3'd0};
      ze = '{6'd0, 6'd5, 6'd0};
      for (int i = 0; i < 3; i++) begin
         m3 = 3'd7; q3 = 3'd7;
         pulse_reset();
         tick(4);               // R=49 first so a stuck-zero cannot pass
         m3 = zm[i]; q3 = zq[i];
         tick(4);
         n_cmp++;
         if (r3 !== ze[i]) begin
            n_err++; $display("FAIL zero_ident_%0d: got %0d want %0d", i, r3, ze[i]);
         end
      end
   endtask

   task automatic test_mid_change();
      m3 = 3'd5; q3 = 3'd3;
      pulse_reset();
      tick(1);
      m3 = 3'd7; q3 = 3'd6;
      tick(3);
      n_cmp++;
      if (r3 !== 6'd15) begin
         n_err++; $display("FAIL mid_old: got %0d want 15", r3);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1);
         n_cmp++;
         if (r3 !== 6'd15) begin
            n_err++; $display("FAIL mid_hold cyc%0d: got %0d want 15", i, r3);
         end
      end
      tick(1);
      n_cmp++;
      if (r3 !== 6'd42) begin
         n_err++; $display("FAIL mid_new: got %0d want 42", r3);
      end
   endtask

   task automatic test_reset_mid();
      m3 = 3'd7; q3 = 3'd5;
      pulse_reset();
      tick(4);
      n_cmp++;
      if (r3 !== 6'd35) begin
         n_err++; $display("FAIL rmid_pre: got %0d want 35", r3);
      end
      tick(2);
      rstn = 1'b1;
      m3 = 3'd6; q3 = 3'd3;
      tick(1);
      n_cmp++;
      if (r3 !== 6'd0) begin
         n_err++; $display("FAIL rmid_clear: got %0d want 0", r3);
      end
      rstn = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         n_cmp++;
         if (r3 !== 6'd0) begin
            n_err++; $display("FAIL rmid_wait edge%0d: got %0d want 0", i, r3);
         end
      end
      tick(1);
      n_cmp++;
      if (r3 !== 6'd18) begin
         n_err++; $display("FAIL rmid_after: got %0d want 18", r3);
      end
   endtask

   task automatic test_n1();
      for (int i = 0; i < 4; i++) begin
         m1 = 1'((i >> 1) & 1); q1 = 1'(i & 1);
         pulse_reset();
         tick(2);
         n_cmp++;
         if (r1 !== {1'b0, m1 & q1}) begin
            n_err++; $display("FAIL n1_%0d: got %0d want %0d", i, r1, m1 & q1);
         end
      end
   endtask

   task automatic test_sweep();
      logic [5:0] exp;
      m3 = 3'd0; q3 = 3'd0;
      pulse_reset();
      for (int m = 0; m < 8; m++) begin
         for (int q = 0; q < 8; q++) begin
            m3 = 3'(m); q3 = 3'(q);
            tick(4);
            exp = 6'(m * q);
            n_cmp++;
            if (r3 !== exp) begin
               n_err++; $display("FAIL sweep %0d*%0d: got %0d want %0d", m, q, r3, exp);
            end
         end
      end
   endtask

   initial begin
      rstn = 1'b1;
      m3 = '0; q3 = '0; m8 = '0; q8 = '0; m1 = '0; q1 = '0;
      tick(1);
      test_reset();
      test_operand_switch();
      test_max();
      test_wide();
      test_zero_identity();
      test_mid_change();
      test_reset_mid();
      test_n1();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
